uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Frames the byte stream from the UART receiver (rx_data/rx_done, 12 MHz domain) into validated command packets for the tarot reader core. Hunts for a start-of-frame byte, collects opcode, length and payload into an internal buffer, checks an XOR checksum, then presents the command with a valid/ready handshake. Aborts and reports malformed, oversized, stalled or overrun frames.

Parameters:
MAX_PAYLOAD, 8, maximum payload bytes per frame (1..15); also the depth of the payload buffer
SOF_BYTE, 8'hA5, start-of-frame marker
TIMEOUT_CYCLES, 4166, inter-byte gap in clk cycles that aborts a partial frame (about 20 bit times at 57600 baud)

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte, valid when rx_done=1
rx_done  in  1  one-cycle strobe per received byte
cmd_valid  out  1  complete validated command is held
cmd_ready  in  1  consumer accepts the command
cmd_opcode  out  8  opcode of the held command
cmd_len  out  4  payload byte count of the held command (0..MAX_PAYLOAD)
cmd_rd_addr  in  4  payload byte index the consumer reads
cmd_rd_data  out  8  payload[cmd_rd_addr], combinational read; 0 if cmd_rd_addr >= cmd_len
err_pulse  out  1  one-cycle strobe on frame abort
err_code  out  2  abort reason, valid with err_pulse: 0 checksum, 1 length, 2 timeout, 3 overrun

Behaviour:
- Single clock; reset is synchronous and active-high; both ports are named as the codebase does (clk, rst).
- Frame format: SOF, OPCODE, LEN, LEN payload bytes, CHK. CHK = OPCODE ^ LEN ^ all payload bytes.
- Reset: state=HUNT, cmd_valid=0, cmd_opcode=0, cmd_len=0, err_pulse=0, err_code=0, buffer contents don't-care, timeout counter=0.
- Only cycles with rx_done=1 carry bytes. rx_data is ignored otherwise.
- HUNT: a byte equal to SOF_BYTE moves to OPC. Any other byte is discarded silently, with no error.
- OPC: latch the opcode, chk_acc=byte, -> LEN.
- LEN: if byte > MAX_PAYLOAD, err_pulse with code 1 and -> HUNT. Otherwise latch the length, chk_acc^=byte, idx=0, and go to PAYLOAD (or to CHK if LEN=0).
- PAYLOAD: buf[idx]=byte, chk_acc^=byte, idx++. After the LEN-th byte -> CHK.
- CHK: if byte==chk_acc, go to HOLD and assert cmd_valid the next cycle (1-cycle latency from the CHK rx_done). Otherwise err_pulse with code 0 and -> HUNT.
- HOLD: cmd_valid=1. cmd_opcode, cmd_len and the buffer are stable until cmd_ready=1.
  - Handshake completes in any cycle where cmd_valid && cmd_ready; cmd_valid=0 and state=HUNT the next cycle.
  - rx_done in the handshake cycle: the byte is treated as a HUNT byte (an SOF starts a new frame).
  - rx_done in HOLD without cmd_ready: byte dropped, err_pulse with code 3, command stays held.
- Timeout: the counter clears on every rx_done and increments each cycle while in OPC, LEN, PAYLOAD or CHK. On reaching TIMEOUT_CYCLES-1: err_pulse with code 2, -> HUNT. The counter is idle in HUNT and HOLD.
- err_pulse lasts exactly one cycle. err_code holds its last value until the next error.
- cmd_opcode and cmd_len update only on successful frame completion. A partial frame never corrupts a held command: HOLD blocks new frames.
- rst at any point (mid-frame or in HOLD) abandons the frame and restores reset values the next cycle, with no err_pulse.
- chk_acc and all data paths are 8 bits with XOR wrap. idx is 4 bits and never exceeds MAX_PAYLOAD.

Optional Feature:
Macro PARSER_ERR_CNT_EN.
- Defined: adds output err_count [7:0]. It increments on every err_pulse, saturates at 255, and is cleared only by rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Valid frame: A5 10 02 33 44 (CHK=10^02^33^44=65) -> cmd_valid 1 cycle after the last rx_done; cmd_opcode=10, cmd_len=2, rd_addr 0->33, 1->44, 2->00. cmd_ready=1 -> cmd_valid=0 the next cycle.
- Bad checksum: A5 10 02 33 44 66 -> err_pulse with err_code=0, no cmd_valid. Then A5 07 00 07 -> cmd_valid, opcode=07, len=0.
- Oversize: A5 01 09 (MAX_PAYLOAD=8) -> err_pulse with code 1 on the LEN byte. Following payload-like bytes (not A5) are ignored in HUNT.
- Timeout: A5 01, then no bytes for 4166 cycles -> err_pulse with code 2 on cycle 4166. A new full frame then parses correctly.
- Overrun and handshake boundary: held command with cmd_ready=0 and a byte 55 arrives -> err code 3, command unchanged. Then cmd_ready=1 with rx_done=1 and byte A5 in the same cycle -> handshake completes and a new frame starts.
- Reset mid-frame: A5 10 02 33, rst for 1 cycle, then 44 65 -> no cmd_valid, no err_pulse; err_count (if PARSER_ERR_CNT_EN) reads 0.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART byte-stream framer: SOF/opcode/len/payload/XOR-checksum into held commands.
// Optional saturating error counter output enabled by PARSER_ERR_CNT_EN.
module uart_cmd_parser #(
  parameter int         MAX_PAYLOAD    = 8,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 4166
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_opcode,
  output logic [3:0] cmd_len,
  input  logic [3:0] cmd_rd_addr,
  output logic [7:0] cmd_rd_data,
  output logic       err_pulse,
  output logic [1:0] err_code
`ifdef PARSER_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    MAX_B   = 8'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  localparam logic [1:0] E_CHK = 2'd0;
  localparam logic [1:0] E_LEN = 2'd1;
  localparam logic [1:0] E_TMO = 2'd2;
  localparam logic [1:0] E_OVR = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT,
    S_OPC,
    S_LEN,
    S_PAY,
    S_CHK,
    S_HOLD
  } state_t;

  state_t        state_q;
  logic          cmd_valid_q;
  logic [7:0]    cmd_opcode_q;
  logic [3:0]    cmd_len_q;
  logic          err_pulse_q;
  logic [1:0]    err_code_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    opc_q;
  logic [3:0]    len_q;
  logic [3:0]    idx_q;
  logic [7:0]    chk_q;
  logic [7:0]    pbuf_q [MAX_PAYLOAD];

  logic       tmo_run;
  logic       tmo_hit;
  logic [7:0] chk_d;
  logic [3:0] idx_d;

  assign tmo_run = (state_q == S_OPC) || (state_q == S_LEN) ||
                   (state_q == S_PAY) || (state_q == S_CHK);
  assign tmo_hit = tmo_run && !rx_done && (tmo_q == TMO_MAX);
  assign chk_d   = chk_q ^ rx_data;
  assign idx_d   = idx_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= 8'h00;
      cmd_len_q    <= 4'h0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 2'd0;
      tmo_q        <= '0;
      opc_q        <= 8'h00;
      len_q        <= 4'h0;
      idx_q        <= 4'h0;
      chk_q        <= 8'h00;
    end else begin
      err_pulse_q <= 1'b0;
      if (rx_done || !tmo_run || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_ONE;
      end
      if (tmo_hit) begin
        err_pulse_q <= 1'b1;
        err_code_q  <= E_TMO;
        state_q     <= S_HUNT;
      end else begin
        unique case (state_q)
          S_HUNT: begin
            if (rx_done && rx_data == SOF_BYTE) begin
              state_q <= S_OPC;
            end
          end
          S_OPC: begin
            if (rx_done) begin
              opc_q   <= rx_data;
              chk_q   <= rx_data;
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (rx_done) begin
              if (rx_data > MAX_B) begin
                err_pulse_q <= 1'b1;
                err_code_q  <= E_LEN;
                state_q     <= S_HUNT;
              end else begin
                len_q   <= rx_data[3:0];
                chk_q   <= chk_d;
                idx_q   <= 4'h0;
                state_q <= (rx_data == 8'h00) ? S_CHK : S_PAY;
              end
            end
          end
          S_PAY: begin
            if (rx_done) begin
              pbuf_q[idx_q[AW-1:0]] <= rx_data;
              chk_q <= chk_d;
              idx_q <= idx_d;
              if (idx_d == len_q) begin
                state_q <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (rx_done) begin
              if (rx_data == chk_q) begin
                cmd_valid_q  <= 1'b1;
                cmd_opcode_q <= opc_q;
                cmd_len_q    <= len_q;
                state_q      <= S_HOLD;
              end else begin
                err_pulse_q <= 1'b1;
                err_code_q  <= E_CHK;
                state_q     <= S_HUNT;
              end
            end
          end
          S_HOLD: begin
            // A byte arriving with the accepting handshake is a fresh hunt byte.
            if (cmd_ready) begin
              cmd_valid_q <= 1'b0;
              if (rx_done && rx_data == SOF_BYTE) begin
                state_q <= S_OPC;
              end else begin
                state_q <= S_HUNT;
              end
            end else if (rx_done) begin
              err_pulse_q <= 1'b1;
              err_code_q  <= E_OVR;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

`ifdef PARSER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (err_pulse_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign cmd_valid   = cmd_valid_q;
  assign cmd_opcode  = cmd_opcode_q;
  assign cmd_len     = cmd_len_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;
  assign cmd_rd_data = (cmd_rd_addr < cmd_len_q) ?
                       pbuf_q[cmd_rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: frame-level reference model,
// random frames plus directed boundary cases.
module tb_uart_cmd_parser;

  localparam int MAXP = 8;
  localparam int TMO  = 4166;

  typedef struct packed {
    logic [7:0]       opc;
    logic [3:0]       len;
    logic [15:0][7:0] pl;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_opcode;
  logic [3:0] cmd_len;
  logic [3:0] cmd_rd_addr;
  logic [7:0] cmd_rd_data;
  logic       err_pulse;
  logic [1:0] err_code;
`ifdef PARSER_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  uart_cmd_parser dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode),
    .cmd_len(cmd_len),
    .cmd_rd_addr(cmd_rd_addr),
    .cmd_rd_data(cmd_rd_data),
    .err_pulse(err_pulse),
    .err_code(err_code)
`ifdef PARSER_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #20 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_err_exp = 0;
  cmd_t cmd_q[$];
  int   err_q[$];
  logic hold_off = 1'b0;
  logic ready_now = 1'b0;
  int   wait_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_cmd();
    cmd_t e;
    if (cmd_q.size() == 0) begin
      check("cmd_unexpected", 32'(cmd_opcode), 32'hFFFF_FFFF);
      return;
    end
    e = cmd_q.pop_front();
    check("cmd_opcode", 32'(cmd_opcode), 32'(e.opc));
    check("cmd_len", 32'(cmd_len), 32'(e.len));
    for (int a = 0; a < 16; a++) begin
      cmd_rd_addr = 4'(a);
      #1;
      check("cmd_rd_data", 32'(cmd_rd_data),
            (a < int'(e.len)) ? 32'(e.pl[a]) : 32'h0);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an error or a command.
  initial begin
    cmd_ready   = 1'b0;
    cmd_rd_addr = 4'h0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (err_pulse) begin
        if (err_q.size() == 0) begin
          check("err_unexpected", 32'(err_code), 32'hFFFF_FFFF);
        end else begin
          check("err_code", 32'(err_code), 32'(err_q.pop_front()));
        end
      end
      if (cmd_ready) begin
        cmd_ready = 1'b0;
        check("valid_drop", 32'(cmd_valid), 32'h0);
        wait_cnt = $urandom_range(0, 3);
      end else if (cmd_valid) begin
        if (hold_off) begin
          if (ready_now) begin
            compare_cmd();
            cmd_ready = 1'b1;
          end
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end else begin
          compare_cmd();
          cmd_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_gap(input logic [7:0] b);
    idle($urandom_range(0, 2));
    send_byte(b);
  endtask

  task automatic push_err(input int c);
    err_q.push_back(c);
    n_err_exp++;
  endtask

  task automatic drain();
    int t = 0;
    while ((cmd_q.size() != 0 || err_q.size() != 0 || cmd_valid ||
            cmd_ready) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) check("drain_timeout", 32'(t), 32'h0);
  endtask

  function automatic logic [7:0] frame_chk(input logic [7:0] opc,
                                           input int len,
                                           input logic [15:0][7:0] pl);
    logic [7:0] c = opc ^ 8'(len);
    for (int i = 0; i < len; i++) c ^= pl[i];
    return c;
  endfunction

  // good=0 corrupts the checksum and expects a checksum abort instead.
  task automatic do_frame(input logic [7:0] opc, input int len,
                          input logic [15:0][7:0] pl, input bit good);
    cmd_t       e;
    logic [7:0] c = frame_chk(opc, len, pl);
    if (good) begin
      e.opc = opc;
      e.len = 4'(len);
      e.pl  = pl;
      cmd_q.push_back(e);
    end else begin
      c ^= 8'($urandom_range(1, 255));
      push_err(0);
    end
    send_gap(8'hA5);
    send_gap(opc);
    send_gap(8'(len));
    for (int i = 0; i < len; i++) send_gap(pl[i]);
    send_gap(c);
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == 8'hA5);
      send_gap(b);
    end
  endtask

  logic [15:0][7:0] pl;
  logic [7:0]       fb[$];
  int               n;
  int               tmo_left;

  initial begin
    rst     = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b0;
    idle(3);
    #1;
    rst = 1'b0;
    check("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("rst_cmd_opcode", 32'(cmd_opcode), 32'h0);
    check("rst_cmd_len", 32'(cmd_len), 32'h0);
    check("rst_err_pulse", 32'(err_pulse), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);

    // Valid frame and one-cycle latency.
    pl = '0;
    pl[0] = 8'h33;
    pl[1] = 8'h44;
    do_frame(8'h10, 2, pl, 1'b1);
    check("valid_latency", 32'(cmd_valid), 32'h1);
    drain();

    // Bad checksum then zero-length frame.
    push_err(0);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h66);
    drain();
    pl = '0;
    do_frame(8'h07, 0, pl, 1'b1);
    drain();

    // Oversize length, then non-SOF bytes ignored.
    push_err(1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h11);
    drain();

    // Exact timeout position.
    push_err(2);
    send_byte(8'hA5); send_byte(8'h01);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!err_pulse && n < 5000);
    check("timeout_cycle", 32'(n), 32'(TMO));
    drain();
    pl = '0;
    pl[0] = 8'hC3;
    do_frame(8'h42, 1, pl, 1'b1);
    drain();

    // Overrun while held, then handshake with a same-cycle SOF.
    hold_off = 1'b1;
    pl = '0;
    pl[0] = 8'h5A;
    do_frame(8'h22, 1, pl, 1'b1);
    idle(2);
    push_err(3);
    send_byte(8'h55);
    idle(2);
    #1;
    check("overrun_held", 32'(cmd_valid), 32'h1);
    @(posedge clk);
    #1;
    rx_data   = 8'hA5;
    rx_done   = 1'b1;
    ready_now = 1'b1;
    @(posedge clk);
    #1;
    rx_done   = 1'b0;
    ready_now = 1'b0;
    hold_off  = 1'b0;
    begin
      cmd_t e;
      e.opc = 8'h3C;
      e.len = 4'h0;
      e.pl  = '0;
      cmd_q.push_back(e);
    end
    send_byte(8'h3C); send_byte(8'h00); send_byte(8'h3C);
    drain();

`ifdef PARSER_ERR_CNT_EN
    check("err_count_total", 32'(err_count), 32'(n_err_exp));
`endif

    // Randomized frames.
    tmo_left = 3;
    for (int f = 0; f < 60; f++) begin
      int kind = $urandom_range(0, 9);
      int len  = $urandom_range(0, MAXP);
      for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
      if (kind == 8 && tmo_left == 0) kind = 0;
      if (kind <= 4) begin
        do_frame(8'($urandom), len, pl, 1'b1);
      end else if (kind == 9) begin
        do_frame(8'($urandom), 0, pl, 1'b1);
      end else if (kind == 5) begin
        do_frame(8'($urandom), len, pl, 1'b0);
      end else if (kind == 6) begin
        push_err(1);
        send_gap(8'hA5);
        send_gap(8'($urandom));
        send_gap(8'($urandom_range(MAXP + 1, 255)));
        send_junk($urandom_range(0, 3));
      end else if (kind == 7) begin
        send_junk($urandom_range(1, 5));
      end else begin
        tmo_left--;
        fb.delete();
        fb.push_back(8'hA5);
        fb.push_back(pl[15]);
        fb.push_back(8'(len));
        for (int i = 0; i < len; i++) fb.push_back(pl[i]);
        n = $urandom_range(1, fb.size());
        push_err(2);
        for (int i = 0; i < n; i++) send_gap(fb[i]);
        idle(TMO + 10);
      end
      drain();
    end

    // Reset mid-frame abandons it silently.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_cmd_valid", 32'(cmd_valid), 32'h0);
    check("midrst_opcode", 32'(cmd_opcode), 32'h0);
    check("midrst_err_code", 32'(err_code), 32'h0);
    send_byte(8'h44); send_byte(8'h65);
    idle(10);
`ifdef PARSER_ERR_CNT_EN
    check("midrst_err_count", 32'(err_count), 32'h0);
`endif
    drain();

    check("cmd_q_empty", 32'(cmd_q.size()), 32'h0);
    check("err_q_empty", 32'(err_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
